// File: rtl/lbp_engine.sv
// Local Binary Pattern engine: streams a gray image through a 3x3 window
// and writes one 8-bit LBP code per interior pixel.
module lbp_engine #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gray_ready,
   output logic              gray_req,
   output logic [ADDR_W-1:0] gray_addr,
   input  logic [DATA_W-1:0] gray_data,
   output logic              lbp_valid,
   output logic [ADDR_W-1:0] lbp_addr,
   output logic [DATA_W-1:0] lbp_data,
   output logic              finish
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH9 = 3'd1;
   localparam logic [2:0] FETCH3 = 3'd2;
   localparam logic [2:0] WRITE  = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 2);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 2);

   logic [2:0]        state, n_state;
   logic [1:0]        rk, ck, n_rk, n_ck;
   logic [ADDR_W-1:0] row, col, n_row, n_col;
   logic [DATA_W-1:0] w   [3][3];
   logic [DATA_W-1:0] w_n [3][3];
   logic [DATA_W-1:0] gc;
   logic [7:0]        code;
   logic [ADDR_W-1:0] f_row, f_col, f_addr;
   logic              n_fetch;

   // rk/ck walk the window slot being filled; a column refill starts at ck=2
   always_comb begin
      n_state = state;
      n_rk    = rk;
      n_ck    = ck;
      n_row   = row;
      n_col   = col;
      w_n     = w;
      unique case (state)
         IDLE: begin
            if (gray_ready) begin
               n_state = FETCH9;
               n_rk    = 2'd0;
               n_ck    = 2'd0;
            end
         end
         FETCH9, FETCH3: begin
            w_n[rk][ck] = gray_data;
            if (rk == 2'd2) begin
               n_rk = 2'd0;
               if (ck == 2'd2) n_state = WRITE;
               else n_ck = ck + 2'd1;
            end else begin
               n_rk = rk + 2'd1;
            end
         end
         WRITE: begin
            if (col < COL_LAST) begin
               for (int i = 0; i < 3; i++) begin
                  w_n[i][0] = w[i][1];
                  w_n[i][1] = w[i][2];
               end
               n_col   = col + ONE;
               n_state = FETCH3;
               n_rk    = 2'd0;
               n_ck    = 2'd2;
            end else if (row < ROW_LAST) begin
               n_row   = row + ONE;
               n_col   = ONE;
               n_state = FETCH9;
               n_rk    = 2'd0;
               n_ck    = 2'd0;
            end else begin
               n_state = DONE;
            end
         end
         DONE: n_state = DONE;
         default: n_state = IDLE;
      endcase
   end

   // Code is built from the next window so the WRITE outputs can be registered
   always_comb begin
      gc   = w_n[1][1];
      code = {w_n[2][2] >= gc, w_n[2][1] >= gc, w_n[2][0] >= gc,
              w_n[1][2] >= gc, w_n[1][0] >= gc,
              w_n[0][2] >= gc, w_n[0][1] >= gc, w_n[0][0] >= gc};
   end

   always_comb begin
      n_fetch = (n_state == FETCH9) || (n_state == FETCH3);
      f_row   = n_row - ONE + ADDR_W'(n_rk);
      f_col   = n_col - ONE + ADDR_W'(n_ck);
      f_addr  = f_row * STRIDE + f_col;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rk        <= 2'd0;
         ck        <= 2'd0;
         row       <= ONE;
         col       <= ONE;
         w         <= '{default: '0};
         gray_req  <= 1'b0;
         gray_addr <= '0;
         lbp_valid <= 1'b0;
         lbp_addr  <= '0;
         lbp_data  <= '0;
         finish    <= 1'b0;
      end else begin
         state     <= n_state;
         rk        <= n_rk;
         ck        <= n_ck;
         row       <= n_row;
         col       <= n_col;
         w         <= w_n;
         gray_req  <= n_fetch;
         gray_addr <= n_fetch ? f_addr : '0;
         lbp_valid <= (n_state == WRITE);
         lbp_addr  <= (n_state == WRITE) ? n_row * STRIDE + n_col : '0;
         lbp_data  <= (n_state == WRITE) ? DATA_W'(code) : '0;
         finish    <= (n_state == DONE);
      end
   end

endmodule

// File: tb/tb_lbp_engine.sv
// Bench for lbp_engine: gray memory model, golden LBP scoreboard,
// spot-value table, idle hold and mid-run reset sequences.
module tb_lbp_engine;

   localparam int W       = 16;
   localparam int H       = 12;
   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int ROWS    = H - 2;
   localparam int COLS    = W - 2;
   localparam int PER_ROW = 10 + 4 * (W - 3);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          gray_ready = 1'b0;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic [DW-1:0] gray_data;
   logic          lbp_valid;
   logic [AW-1:0] lbp_addr;
   logic [DW-1:0] lbp_data;
   logic          finish;

   always #5 clk = ~clk;

   lbp_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .gray_ready(gray_ready),
      .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
      .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
      .finish(finish)
   );

   logic [7:0] mem [W*H];
   logic [7:0] res [W*H];

   assign gray_data = gray_req ? mem[gray_addr] : '0;

   typedef struct {
      int         addr;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int         kind;
      int         r;
      int         c;
      logic [7:0] code;
   } vec_t;
   vec_t vecs[10];

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int border_hits = 0;
   int bad_reads = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock; outputs sampled and result memory written on the negedge
   task automatic tick();
      exp_t e;
      int   a;
      @(negedge clk);
      if (gray_req && int'(gray_addr) >= W * H) bad_reads++;
      if (lbp_valid) begin
         a = int'(lbp_addr);
         pulses++;
         if (a < W * H) res[a] = lbp_data;
         if (a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1)
            border_hits++;
         if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("lbp_addr", a, e.addr);
            chk("lbp_data", int'(lbp_data), int'(e.data));
         end
      end
   endtask

   task automatic load(input int kind);
      int         dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
      int         dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
      logic [7:0] gc, code;
      exp_t       e;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            res[r*W+c] = 8'h00;
            case (kind)
               0:       mem[r*W+c] = 8'h37;
               1:       mem[r*W+c] = 8'(c);
               2:       mem[r*W+c] = (r == 6 && c == 8) ? 8'd0 : 8'd100;
               default: mem[r*W+c] = 8'($urandom_range(0, 7) * 32);
            endcase
         end
      sb.delete();
      for (int r = 1; r < H - 1; r++)
         for (int c = 1; c < W - 1; c++) begin
            gc = mem[r*W+c];
            for (int p = 0; p < 8; p++)
               code[p] = (mem[(r+dr[p])*W + c + dc[p]] >= gc);
            e.addr = r * W + c;
            e.data = code;
            sb.push_back(e);
         end
   endtask

   task automatic run_image(input int kind, input int idle);
      int n, reqs, p0, b0, r0, bres;
      load(kind);
      reset = 1'b1;
      gray_ready = 1'b0;
      tick();
      tick();
      chk("reset_outputs", int'({gray_req, lbp_valid, finish,
                                 gray_addr, lbp_addr, lbp_data}), 0);
      reset = 1'b0;
      reqs = 0;
      repeat (idle) begin
         tick();
         if (gray_req) reqs++;
      end
      chk("idle_no_req", reqs, 0);
      p0 = pulses;
      b0 = border_hits;
      r0 = bad_reads;
      gray_ready = 1'b1;
      n = 0;
      tick();
      n++;
      gray_ready = 1'b0;
      while (!finish && n < ROWS * PER_ROW + 20) begin
         tick();
         n++;
      end
      chk("finish_reached", int'(finish), 1);
      chk("finish_latency", int'(n <= ROWS * PER_ROW + 2), 1);
      chk("pulse_count", pulses - p0, ROWS * COLS);
      chk("border_pulses", border_hits - b0, 0);
      chk("read_range", bad_reads - r0, 0);
      chk("sb_leftover", sb.size(), 0);
      bres = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if ((r == 0 || r == H - 1 || c == 0 || c == W - 1) &&
                res[r*W+c] != 8'h00) bres++;
      chk("border_results", bres, 0);
      repeat (5) tick();
      chk("finish_held", int'({finish, lbp_valid, gray_req}), 4);
      for (int i = 0; i < 10; i++)
         if (vecs[i].kind == kind)
            chk($sformatf("spot_k%0d_r%0d_c%0d", kind, vecs[i].r, vecs[i].c),
                int'(res[vecs[i].r*W + vecs[i].c]), int'(vecs[i].code));
   endtask

   initial begin
      vecs[0] = '{0, 1, 1, 8'hFF};
      vecs[1] = '{0, H - 2, W - 2, 8'hFF};
      vecs[2] = '{1, 1, 1, 8'hD6};
      vecs[3] = '{1, 5, 7, 8'hD6};
      vecs[4] = '{1, H - 2, W - 2, 8'hD6};
      vecs[5] = '{2, 6, 8, 8'hFF};
      vecs[6] = '{2, 5, 7, 8'h7F};
      vecs[7] = '{2, 7, 9, 8'hFE};
      vecs[8] = '{2, 6, 7, 8'hEF};
      vecs[9] = '{2, 3, 3, 8'hFF};

      run_image(0, 2);
      run_image(1, 50);
      run_image(2, 3);
      run_image(3, 4);

      // Abort mid-run, then a clean rerun must still match the golden image
      load(3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      gray_ready = 1'b1;
      repeat (300) tick();
      #2;
      reset = 1'b1;
      gray_ready = 1'b0;
      #1;
      chk("async_reset_outputs", int'({gray_req, lbp_valid, finish,
                                       gray_addr, lbp_addr, lbp_data}), 0);
      tick();
      chk("reset_hold_outputs", int'({gray_req, lbp_valid, finish}), 0);
      run_image(3, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
